osd_scm_ctrl: RTL and testbench
===============================

Name: osd_scm_ctrl

Overview:
- Second-generation subnet control module register backend.
- Serves the read-only system identity registers plus writable reset control:
  - global system reset;
  - per-CPU reset select;
  - self-timed system reset pulse.
- Sits behind the module's status/control interface (reg_* handshake).
- Drives sys_rst/cpu_rst into the system reset tree.
- Differs from the first generation in four ways: registered responses, 32-bit SYSTEMID, writable state, and a NUM_CPU-wide reset vector.

Parameters:
- SYSTEMID, 32'h0, 32-bit system identifier, exposed as two 16-bit words.
- NUM_MOD, 0, number of debug modules in the subnet (16-bit value).
- MAX_PKT_LEN, 0, maximum debug packet length in flits (16-bit value).
- NUM_CPU, 1, number of CPU reset outputs, legal range 1..16.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- reg_request  in  1  register access request; held until reg_ack.
- reg_write  in  1  1=write, 0=read.
- reg_addr  in  16  register address.
- reg_size  in  2  access size; 0=16 bit, other values are illegal.
- reg_wdata  in  16  write data.
- reg_ack  out  1  one-cycle response strobe.
- reg_err  out  1  error flag, valid with reg_ack.
- reg_rdata  out  16  read data, valid with reg_ack.
- sys_rst  out  1  system reset request.
- cpu_rst  out  NUM_CPU  per-CPU reset request.

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high; all state clears immediately on assertion.
- Reset values: reg_ack=0, reg_err=0, reg_rdata=0, sys_rst=0, cpu_rst=0, CTRL=0, CPU_SEL=0, pulse counter=0.
- FSM IDLE/RESP:
  - IDLE: if reg_request=1, decode, capture the result and go to RESP.
  - RESP: reg_ack=1 with registered reg_err/reg_rdata for exactly one cycle, then return to IDLE.
  - reg_request is ignored in RESP.
  - Latency is 1 cycle from request to ack; back-to-back accesses complete every 2 cycles.
- Register map (16-bit):
  - 0x200 SYSTEMID[15:0], read-only.
  - 0x201 SYSTEMID[31:16], read-only.
  - 0x202 NUM_MOD, read-only.
  - 0x203 MAX_PKT_LEN, read-only.
  - 0x204 CTRL, read/write: bit0 SYS_RST, bit1 CPU_RST_ALL; bits 15:2 read 0 and ignore writes.
  - 0x205 CPU_SEL, read/write: bits NUM_CPU-1:0; upper bits read 0 and ignore writes.
  - 0x206 PULSE, read/write: a write loads the pulse counter with wdata; a read returns the remaining count.
- Write side effects commit on the IDLE→RESP edge, i.e. visible on outputs in the ack cycle.
- Errors (reg_err=1 with ack, no state change, reg_rdata=0):
  - unmapped address;
  - reg_size≠0;
  - write to 0x200–0x203.
- Pulse counter, 16-bit:
  - decrements by 1 each cycle while nonzero and saturates at 0.
  - A PULSE write in the same cycle overrides the decrement (reload).
  - Writing 0 cancels a running pulse.
- Outputs, registered:
  - sys_rst = CTRL.SYS_RST | (cnt≠0).
  - cpu_rst[i] = sys_rst_next | CTRL.CPU_RST_ALL | CPU_SEL[i].
  - A PULSE write of N gives sys_rst high for exactly N cycles, starting in the ack cycle.
- This block is not itself reset by sys_rst; there is no feedback loop.

Optional Feature:
- Macro OSD_SCM_CTRL_RST_STATUS_EN.
- When defined, read-only register 0x207 RST_STATUS is added:
  - bit0 = sys_rst.
  - bit1 = sticky "pulse completed" flag: set when the counter transitions 1→0, cleared on read of 0x207.
- Writes to 0x207 return reg_err.
- When undefined, 0x207 is unmapped (reg_err on any access) and no flag flop exists.

Decomposition:
- Package osd_scm_pkg holds:
  - address constants SCM_REG_SYSID_LO…SCM_REG_RST_STATUS;
  - CTRL bit-index constants;
  - enum typedef scm_state_t {IDLE, RESP}.
- One sub-module, osd_rst_pulse: 16-bit loadable down-counter with load/value inputs, active output and done strobe; the done strobe feeds the optional status flag.

Test Plan:
- SYSTEMID=32'hCAFE_0042: read 0x200 then 0x201 → rdata 0x0042 then 0xCAFE, err=0, each acked exactly 1 cycle after request.
- Write 0x200 → err=1, state unchanged. Read with size=1 → err=1. Read 0x2FF → err=1, rdata=0.
- NUM_CPU=4: write CPU_SEL=0xFFFF → cpu_rst=4'hF, sys_rst=0; readback=0x000F. Write CTRL=0x2, CPU_SEL=0 → cpu_rst=4'hF.
- Write PULSE=5 → sys_rst and all cpu_rst high exactly 5 cycles; reload to 3 mid-pulse → 3 more cycles; write 0 → immediate drop next cycle.
- Assert rst during a pulse and with CTRL=0x1 → sys_rst=0, cpu_rst=0, reg_ack=0 immediately (async); after release, CTRL reads 0.
- With OSD_SCM_CTRL_RST_STATUS_EN: pulse 2 completes → 0x207 reads 0x0002, a second read returns 0x0000. Without the macro → 0x207 read returns err=1.

Source files
------------

// File: rtl/osd_scm_pkg.sv
// Shared constants and types for the subnet control module register backend.
// Optional macro: OSD_SCM_CTRL_RST_STATUS_EN (adds RST_STATUS at 0x207).
package osd_scm_pkg;

    localparam logic [15:0] SCM_REG_SYSID_LO   = 16'h0200;
    localparam logic [15:0] SCM_REG_SYSID_HI   = 16'h0201;
    localparam logic [15:0] SCM_REG_NUM_MOD    = 16'h0202;
    localparam logic [15:0] SCM_REG_MAX_PKT    = 16'h0203;
    localparam logic [15:0] SCM_REG_CTRL       = 16'h0204;
    localparam logic [15:0] SCM_REG_CPU_SEL    = 16'h0205;
    localparam logic [15:0] SCM_REG_PULSE      = 16'h0206;
    localparam logic [15:0] SCM_REG_RST_STATUS = 16'h0207;

    localparam int CTRL_SYS_RST     = 0;
    localparam int CTRL_CPU_RST_ALL = 1;
    localparam int CTRL_W           = 2;

    typedef enum logic {
        IDLE,
        RESP
    } scm_state_t;

endpackage

// File: rtl/osd_scm_ctrl_pulse.sv
// Self-timed reset pulse: 16-bit loadable down-counter, saturating at zero.
// A load in the same cycle overrides the decrement; loading 0 cancels.
module osd_rst_pulse (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    output logic [15:0] count,
    output logic [15:0] count_next,
    output logic        active,
    output logic        done
);

    // Next count: reload wins, otherwise count down to zero.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = value;
        end else if (count != 16'd0) begin
            count_next = count - 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'd0;
        end else begin
            count <= count_next;
        end
    end

    // Active follows the next value so the pulse is visible in the write ack.
    always_comb begin
        active = (count_next != 16'd0);
        done   = !load && (count == 16'd1);
    end

endmodule

// File: rtl/osd_scm_ctrl.sv
// Subnet control module register backend: identity regs and reset control.
// Optional macro: OSD_SCM_CTRL_RST_STATUS_EN adds RST_STATUS at 0x207.
module osd_scm_ctrl
    import osd_scm_pkg::*;
#(
    parameter logic [31:0] SYSTEMID    = 32'h0,
    parameter logic [15:0] NUM_MOD     = 16'h0,
    parameter logic [15:0] MAX_PKT_LEN = 16'h0,
    parameter int          NUM_CPU     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_request,
    input  logic               reg_write,
    input  logic [15:0]        reg_addr,
    input  logic [1:0]         reg_size,
    input  logic [15:0]        reg_wdata,
    output logic               reg_ack,
    output logic               reg_err,
    output logic [15:0]        reg_rdata,
    output logic               sys_rst,
    output logic [NUM_CPU-1:0] cpu_rst
);

    scm_state_t         state;
    scm_state_t         next_state;
    logic [CTRL_W-1:0]  ctrl;
    logic [CTRL_W-1:0]  ctrl_next;
    logic [NUM_CPU-1:0] cpu_sel;
    logic [NUM_CPU-1:0] sel_next;
    logic [15:0]        sel_ext;
    logic               capture;
    logic               dec_err;
    logic [15:0]        dec_rdata;
    logic               pulse_load;
    logic [15:0]        pulse_count;
    logic [15:0]        pulse_count_next;
    logic               pulse_active;
    logic               pulse_done;
    logic               sys_rst_next;
    logic [NUM_CPU-1:0] cpu_rst_next;
    logic               status_rd;

`ifdef OSD_SCM_CTRL_RST_STATUS_EN
    logic               status_flag;
`else
    logic               unused_ok;
    assign unused_ok = pulse_done;
`endif

    osd_rst_pulse u_pulse (
        .clk        (clk),
        .rst        (rst),
        .load       (pulse_load),
        .value      (reg_wdata),
        .count      (pulse_count),
        .count_next (pulse_count_next),
        .active     (pulse_active),
        .done       (pulse_done)
    );

    // Zero-extended view of CPU_SEL for readback.
    always_comb begin
        sel_ext              = '0;
        sel_ext[NUM_CPU-1:0] = cpu_sel;
    end

    // Next-state logic and access decode; state changes only on legal writes.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        dec_err    = 1'b0;
        dec_rdata  = 16'h0;
        ctrl_next  = ctrl;
        sel_next   = cpu_sel;
        pulse_load = 1'b0;
        status_rd  = 1'b0;
        unique case (state)
            IDLE: begin
                if (reg_request) begin
                    next_state = RESP;
                    capture    = 1'b1;
                    if (reg_size != 2'd0) begin
                        dec_err = 1'b1;
                    end else begin
                        unique case (reg_addr)
                            SCM_REG_SYSID_LO: begin
                                if (reg_write) dec_err = 1'b1;
                                else dec_rdata = SYSTEMID[15:0];
                            end
                            SCM_REG_SYSID_HI: begin
                                if (reg_write) dec_err = 1'b1;
                                else dec_rdata = SYSTEMID[31:16];
                            end
                            SCM_REG_NUM_MOD: begin
                                if (reg_write) dec_err = 1'b1;
                                else dec_rdata = NUM_MOD;
                            end
                            SCM_REG_MAX_PKT: begin
                                if (reg_write) dec_err = 1'b1;
                                else dec_rdata = MAX_PKT_LEN;
                            end
                            SCM_REG_CTRL: begin
                                if (reg_write) ctrl_next = reg_wdata[CTRL_W-1:0];
                                else dec_rdata = {14'h0, ctrl};
                            end
                            SCM_REG_CPU_SEL: begin
                                if (reg_write) sel_next = reg_wdata[NUM_CPU-1:0];
                                else dec_rdata = sel_ext;
                            end
                            SCM_REG_PULSE: begin
                                if (reg_write) pulse_load = 1'b1;
                                else dec_rdata = pulse_count;
                            end
`ifdef OSD_SCM_CTRL_RST_STATUS_EN
                            SCM_REG_RST_STATUS: begin
                                if (reg_write) begin
                                    dec_err = 1'b1;
                                end else begin
                                    dec_rdata = {14'h0, status_flag, sys_rst};
                                    status_rd = 1'b1;
                                end
                            end
`endif
                            default: dec_err = 1'b1;
                        endcase
                    end
                end
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reset outputs computed from post-write state so they show in the ack cycle.
    always_comb begin
        sys_rst_next = ctrl_next[CTRL_SYS_RST] | pulse_active;
        cpu_rst_next = {NUM_CPU{sys_rst_next | ctrl_next[CTRL_CPU_RST_ALL]}}
                     | sel_next;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered response and control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_ack   <= 1'b0;
            reg_err   <= 1'b0;
            reg_rdata <= 16'h0;
            ctrl      <= '0;
            cpu_sel   <= '0;
            sys_rst   <= 1'b0;
            cpu_rst   <= '0;
        end else begin
            reg_ack   <= capture;
            reg_err   <= capture & dec_err;
            reg_rdata <= capture ? dec_rdata : 16'h0;
            ctrl      <= ctrl_next;
            cpu_sel   <= sel_next;
            sys_rst   <= sys_rst_next;
            cpu_rst   <= cpu_rst_next;
        end
    end

`ifdef OSD_SCM_CTRL_RST_STATUS_EN
    // Sticky completion flag; a completion in the read cycle is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_flag <= 1'b0;
        end else if (pulse_done) begin
            status_flag <= 1'b1;
        end else if (status_rd) begin
            status_flag <= 1'b0;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = status_rd;
`endif

endmodule

// File: tb/tb_osd_scm_ctrl.sv
// Self-checking bench for osd_scm_ctrl (SYSTEMID=CAFE0042, NUM_CPU=4).
// Honors OSD_SCM_CTRL_RST_STATUS_EN when defined for the build.
module tb_osd_scm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_request = 1'b0;
    logic        reg_write = 1'b0;
    logic [15:0] reg_addr = 16'h0;
    logic [1:0]  reg_size = 2'd0;
    logic [15:0] reg_wdata = 16'h0;
    logic        reg_ack;
    logic        reg_err;
    logic [15:0] reg_rdata;
    logic        sys_rst;
    logic [3:0]  cpu_rst;

    int n_vec = 0;
    int n_bad = 0;

    logic       ack_sys;
    logic [3:0] ack_cpu;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [15:0] wdata;
        logic        err;
        logic [15:0] rdata;
        logic        sys;
        logic [3:0]  cpu;
    } vec_t;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        logic        chk_rdata;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    osd_scm_ctrl #(
        .SYSTEMID    (32'hCAFE_0042),
        .NUM_MOD     (16'd7),
        .MAX_PKT_LEN (16'd64),
        .NUM_CPU     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_request (reg_request),
        .reg_write   (reg_write),
        .reg_addr    (reg_addr),
        .reg_size    (reg_size),
        .reg_wdata   (reg_wdata),
        .reg_ack     (reg_ack),
        .reg_err     (reg_err),
        .reg_rdata   (reg_rdata),
        .sys_rst     (sys_rst),
        .cpu_rst     (cpu_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic access(input string nm, input logic wr,
                          input logic [15:0] addr, input logic [1:0] size,
                          input logic [15:0] wd, input logic e_err,
                          input logic [15:0] e_rd);
        exp_t x;
        int   n;
        sb.push_back('{e_err, e_rd, (!wr || e_err)});
        reg_request = 1'b1;
        reg_write   = wr;
        reg_addr    = addr;
        reg_size    = size;
        reg_wdata   = wd;
        @(posedge clk); #1;
        n = 1;
        while (!reg_ack && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        reg_request = 1'b0;
        chk({nm, " latency"}, n, 1);
        ack_sys = sys_rst;
        ack_cpu = cpu_rst;
        x = sb.pop_front();
        if (reg_ack) begin
            chk({nm, " err"}, reg_err, x.err);
            if (x.chk_rdata) chk({nm, " rdata"}, reg_rdata, x.rdata);
        end else begin
            chk({nm, " ack timeout"}, 0, 1);
        end
        @(posedge clk); #1;
        chk({nm, " ack width"}, reg_ack, 0);
    endtask

    task automatic count_high(output int c, output logic all_cpu);
        c = 0;
        all_cpu = 1'b1;
        while (sys_rst && c < 200) begin
            if (cpu_rst !== 4'hF) all_cpu = 1'b0;
            c++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int   c;
        logic ac;

        tbl.push_back('{0, 16'h0200, 0, 0,      0, 16'h0042, 0, 4'h0});
        tbl.push_back('{0, 16'h0201, 0, 0,      0, 16'hCAFE, 0, 4'h0});
        tbl.push_back('{0, 16'h0202, 0, 0,      0, 16'h0007, 0, 4'h0});
        tbl.push_back('{0, 16'h0203, 0, 0,      0, 16'h0040, 0, 4'h0});
        tbl.push_back('{1, 16'h0200, 0, 16'h1234, 1, 16'h0, 0, 4'h0});
        tbl.push_back('{0, 16'h0200, 0, 0,      0, 16'h0042, 0, 4'h0});
        tbl.push_back('{0, 16'h0200, 1, 0,      1, 16'h0000, 0, 4'h0});
        tbl.push_back('{0, 16'h02FF, 0, 0,      1, 16'h0000, 0, 4'h0});
        tbl.push_back('{1, 16'h0205, 0, 16'hFFFF, 0, 16'h0, 0, 4'hF});
        tbl.push_back('{0, 16'h0205, 0, 0,      0, 16'h000F, 0, 4'hF});
        tbl.push_back('{1, 16'h0204, 0, 16'h0002, 0, 16'h0, 0, 4'hF});
        tbl.push_back('{1, 16'h0205, 0, 16'h0000, 0, 16'h0, 0, 4'hF});
        tbl.push_back('{0, 16'h0204, 0, 0,      0, 16'h0002, 0, 4'hF});
        tbl.push_back('{1, 16'h0204, 0, 16'hFFFF, 0, 16'h0, 1, 4'hF});
        tbl.push_back('{0, 16'h0204, 0, 0,      0, 16'h0003, 1, 4'hF});
        tbl.push_back('{1, 16'h0204, 0, 16'h0000, 0, 16'h0, 0, 4'h0});
        tbl.push_back('{1, 16'h0205, 0, 16'h0005, 0, 16'h0, 0, 4'h5});
        tbl.push_back('{1, 16'h0204, 2, 16'h0001, 1, 16'h0, 0, 4'h5});
        tbl.push_back('{1, 16'h0205, 0, 16'h0000, 0, 16'h0, 0, 4'h0});
        tbl.push_back('{1, 16'h0202, 0, 16'h0009, 1, 16'h0, 0, 4'h0});
        tbl.push_back('{1, 16'h01FF, 0, 16'h0001, 1, 16'h0, 0, 4'h0});
`ifdef OSD_SCM_CTRL_RST_STATUS_EN
        tbl.push_back('{0, 16'h0207, 0, 0,      0, 16'h0000, 0, 4'h0});
`else
        tbl.push_back('{0, 16'h0207, 0, 0,      1, 16'h0000, 0, 4'h0});
`endif
        tbl.push_back('{1, 16'h0207, 0, 16'h0003, 1, 16'h0, 0, 4'h0});

        // reset values while reset is held
        #12;
        chk("rst ack", reg_ack, 0);
        chk("rst err", reg_err, 0);
        chk("rst rdata", reg_rdata, 0);
        chk("rst sys", sys_rst, 0);
        chk("rst cpu", cpu_rst, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            access(nm, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata,
                   tbl[i].err, tbl[i].rdata);
            chk({nm, " sys"}, ack_sys, tbl[i].sys);
            chk({nm, " cpu"}, ack_cpu, tbl[i].cpu);
        end

`ifdef OSD_SCM_CTRL_RST_STATUS_EN
        // pulse of 2 completes, flag reads once then clears
        access("st pulse", 1, 16'h0206, 0, 16'd2, 0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        access("st rd1", 0, 16'h0207, 0, 0, 0, 16'h0002);
        access("st rd2", 0, 16'h0207, 0, 0, 0, 16'h0000);
`endif

        // pulse of 5: high 5 cycles counting the ack cycle
        access("p5", 1, 16'h0206, 0, 16'd5, 0, 16'h0);
        chk("p5 ack sys", ack_sys, 1);
        chk("p5 ack cpu", ack_cpu, 4'hF);
        count_high(c, ac);
        chk("p5 len", c, 4);
        chk("p5 cpu", ac, 1);

        // reload to 3 mid-pulse gives 3 more cycles
        access("pr5", 1, 16'h0206, 0, 16'd5, 0, 16'h0);
        @(posedge clk); #1;
        access("pr3", 1, 16'h0206, 0, 16'd3, 0, 16'h0);
        chk("pr3 ack sys", ack_sys, 1);
        count_high(c, ac);
        chk("pr3 len", c, 2);

        // write 0 cancels immediately
        access("pc5", 1, 16'h0206, 0, 16'd5, 0, 16'h0);
        access("pc0", 1, 16'h0206, 0, 16'd0, 0, 16'h0);
        chk("pc0 ack sys", ack_sys, 0);
        chk("pc0 ack cpu", ack_cpu, 4'h0);
        chk("pc0 sys", sys_rst, 0);

        // remaining count readback
        access("pw10", 1, 16'h0206, 0, 16'd10, 0, 16'h0);
        access("prd", 0, 16'h0206, 0, 0, 0, 16'd9);
        count_high(c, ac);
        chk("prd len", c, 7);

        // async reset during a pulse with CTRL.SYS_RST set
        access("rc1", 1, 16'h0204, 0, 16'h0001, 0, 16'h0);
        access("rp", 1, 16'h0206, 0, 16'd100, 0, 16'h0);
        reg_request = 1'b1;
        reg_write   = 1'b0;
        reg_addr    = 16'h0204;
        reg_size    = 2'd0;
        @(posedge clk); #1;
        reg_request = 1'b0;
        chk("ar pre ack", reg_ack, 1);
        chk("ar pre sys", sys_rst, 1);
        rst = 1'b1;
        #1;
        chk("ar sys", sys_rst, 0);
        chk("ar cpu", cpu_rst, 0);
        chk("ar ack", reg_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        access("ar ctrl", 0, 16'h0204, 0, 0, 0, 16'h0000);
        access("ar pulse", 0, 16'h0206, 0, 0, 0, 16'h0000);
        access("ar sel", 0, 16'h0205, 0, 0, 0, 16'h0000);
        chk("ar sys post", sys_rst, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
